// File: rtl/core_pkg.sv
// Shared Tomasulo-core definitions: producer tag width, comparator encodings
// and the layout of one jump reservation-station entry.
package core_pkg;

    localparam int TAG_W = 4;
    typedef logic [TAG_W-1:0] tag_t;
    localparam tag_t TAG_NONE = '0;

    typedef enum logic [2:0] {
        CMP_NONE = 3'd0,
        CMP_BEQ  = 3'd1,
        CMP_BNE  = 3'd2,
        CMP_BLT  = 3'd3,
        CMP_BGE  = 3'd4,
        CMP_BLTU = 3'd5,
        CMP_BGEU = 3'd6
    } cmp_e;

    typedef struct packed {
        logic        valid;
        logic        jalr;
        cmp_e        cmp_ctrl;
        tag_t        q1;
        logic [31:0] v1;
        tag_t        q2;
        logic [31:0] v2;
        logic [31:0] imm;
        logic [31:0] pc;
        tag_t        dest;
    } rs_entry_t;

    // An operand is woken only by a live broadcast of the tag it waits on.
    function automatic logic operand_hit(tag_t q, logic cdb_valid, tag_t cdb_tag);
        return cdb_valid && (q != TAG_NONE) && (q == cdb_tag);
    endfunction

endpackage

// File: rtl/jump_rs_if.sv
// Dispatch, CDB and jump-FU signals of the jump reservation station.
// The master side feeds ops and broadcasts; the slave side is the station.
interface jump_rs_if;
    import core_pkg::*;

    logic        flush;
    logic        disp_valid;
    logic        disp_ready;
    logic        disp_JALR;
    logic [2:0]  disp_cmp_ctrl;
    tag_t        disp_q1;
    logic [31:0] disp_v1;
    tag_t        disp_q2;
    logic [31:0] disp_v2;
    logic [31:0] disp_imm;
    logic [31:0] disp_PC;
    tag_t        disp_dest;
    logic        cdb_valid;
    tag_t        cdb_tag;
    logic [31:0] cdb_data;
    logic        fu_ready;
    logic        fu_en;
    logic        fu_JALR;
    logic [2:0]  fu_cmp_ctrl;
    logic [31:0] fu_rs1_data;
    logic [31:0] fu_rs2_data;
    logic [31:0] fu_imm;
    logic [31:0] fu_PC;
    tag_t        fu_dest;
    logic        empty;

    modport master (
        output flush, disp_valid, disp_JALR, disp_cmp_ctrl, disp_q1, disp_v1,
               disp_q2, disp_v2, disp_imm, disp_PC, disp_dest,
               cdb_valid, cdb_tag, cdb_data, fu_ready,
        input  disp_ready, fu_en, fu_JALR, fu_cmp_ctrl, fu_rs1_data,
               fu_rs2_data, fu_imm, fu_PC, fu_dest, empty
    );

    modport slave (
        input  flush, disp_valid, disp_JALR, disp_cmp_ctrl, disp_q1, disp_v1,
               disp_q2, disp_v2, disp_imm, disp_PC, disp_dest,
               cdb_valid, cdb_tag, cdb_data, fu_ready,
        output disp_ready, fu_en, fu_JALR, fu_cmp_ctrl, fu_rs1_data,
               fu_rs2_data, fu_imm, fu_PC, fu_dest, empty
    );

endinterface

// File: rtl/jump_rs_entry.sv
// One reservation-station slot: picks its next contents (hold, dispatch load or
// shift from the slot above) and then applies CDB wakeup to whatever it keeps.
module jump_rs_entry
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        load,
    input  rs_entry_t   load_data,
    input  logic        shift_in,
    input  rs_entry_t   shift_data,
    input  logic        cdb_valid,
    input  tag_t        cdb_tag,
    input  logic [31:0] cdb_data,
    output rs_entry_t   data,
    output logic        ready
);

    rs_entry_t base;
    rs_entry_t nxt;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        base = data;
        if (load) begin
            base = load_data;
        end else if (shift_in) begin
            base = shift_data;
        end

        // Wakeup follows the op to its new slot, including a same-cycle dispatch.
        nxt = base;
        if (operand_hit(base.q1, cdb_valid, cdb_tag)) begin
            nxt.q1 = TAG_NONE;
            nxt.v1 = cdb_data;
        end
        if (operand_hit(base.q2, cdb_valid, cdb_tag)) begin
            nxt.q2 = TAG_NONE;
            nxt.v2 = cdb_data;
        end
        if (flush) begin
            nxt = '0;
        end
    end

    // NOTE: state registers use non-blocking assignment; the entry is reset in full
    // (not just its valid bit) so nothing undefined can ever reach the fu_* outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
        end else begin
            data <= nxt;
        end
    end

    assign ready = data.valid && (data.q1 == TAG_NONE) && (data.q2 == TAG_NONE);

endmodule

// File: rtl/jump_rs.sv
// Jump/branch reservation station: collapsing queue (index 0 oldest) that issues
// the oldest fully-ready op to the jump FU as a single-cycle fu_en pulse.
module jump_rs
    import core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    jump_rs_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [CNT_W-1:0] count;
    rs_entry_t        ent       [DEPTH];
    rs_entry_t        shift_src [DEPTH];
    logic [DEPTH-1:0] ready;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic             issue;
    logic             disp_fire;
    logic [CNT_W-1:0] wr_idx;
    rs_entry_t        disp_entry;

    // Occupancy is registered only: a slot freed by this cycle's issue is not offered yet.
    assign bus.disp_ready = (count < CNT_W'(DEPTH));
    assign bus.empty      = (count == '0);
    assign disp_fire      = bus.disp_valid && bus.disp_ready && !bus.flush;
    assign issue          = sel_found && bus.fu_ready && !bus.fu_en && !bus.flush;
    assign wr_idx         = count - CNT_W'(issue);

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        disp_entry          = '0;
        disp_entry.valid    = 1'b1;
        disp_entry.jalr     = bus.disp_JALR;
        disp_entry.cmp_ctrl = cmp_e'(bus.disp_cmp_ctrl);
        disp_entry.q1       = bus.disp_q1;
        disp_entry.v1       = bus.disp_v1;
        disp_entry.q2       = bus.disp_q2;
        disp_entry.v2       = bus.disp_v2;
        disp_entry.imm      = bus.disp_imm;
        disp_entry.pc       = bus.disp_PC;
        disp_entry.dest     = bus.disp_dest;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        if (i == DEPTH - 1) begin : g_last
            assign shift_src[i] = '0;
        end else begin : g_inner
            assign shift_src[i] = ent[i+1];
        end

        // Dispatch lands after the shifted entries, so load overrides shift at wr_idx.
        jump_rs_entry u_entry (
            .clk        (clk),
            .rst        (rst),
            .flush      (bus.flush),
            .load       (disp_fire && (wr_idx == CNT_W'(i))),
            .load_data  (disp_entry),
            .shift_in   (issue && (IDX_W'(i) >= sel_idx)),
            .shift_data (shift_src[i]),
            .cdb_valid  (bus.cdb_valid),
            .cdb_tag    (bus.cdb_tag),
            .cdb_data   (bus.cdb_data),
            .data       (ent[i]),
            .ready      (ready[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (bus.flush) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(disp_fire) - CNT_W'(issue);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.fu_en       <= 1'b0;
            bus.fu_JALR     <= 1'b0;
            bus.fu_cmp_ctrl <= '0;
            bus.fu_rs1_data <= '0;
            bus.fu_rs2_data <= '0;
            bus.fu_imm      <= '0;
            bus.fu_PC       <= '0;
            bus.fu_dest     <= '0;
        end else begin
            bus.fu_en <= issue;
            if (issue) begin
                bus.fu_JALR     <= ent[sel_idx].jalr;
                bus.fu_cmp_ctrl <= ent[sel_idx].cmp_ctrl;
                bus.fu_rs1_data <= ent[sel_idx].v1;
                bus.fu_rs2_data <= ent[sel_idx].v2;
                bus.fu_imm      <= ent[sel_idx].imm;
                bus.fu_PC       <= ent[sel_idx].pc;
                bus.fu_dest     <= ent[sel_idx].dest;
            end
        end
    end

endmodule
